// File: rtl/dma_periph_pkg.sv
// dma_periph_pkg: shared types and constants
// for the DMA peripheral responder slice.
package dma_periph_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    GAP
  } state_t;

  localparam logic DIR_TO_MEM   = 1'b0;
  localparam logic DIR_FROM_MEM = 1'b1;

  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_PROTO    = 2;

endpackage

// File: rtl/dma_peripheral_responder_if.sv
// dma_peripheral_responder_if: DMA-side bus
// (request/ack, strobes, EOP, data bus).
interface dma_peripheral_responder_if;

  logic       DACK;
  logic       IOR_N;
  logic       IOW_N;
  logic       EOP_N;
  logic [7:0] DB_in;
  logic [7:0] DB_out;
  logic       DB_oe;
  logic       DREQ;

  modport master (
    output DACK, IOR_N, IOW_N, EOP_N, DB_in,
    input  DB_out, DB_oe, DREQ
  );

  modport slave (
    input  DACK, IOR_N, IOW_N, EOP_N, DB_in,
    output DB_out, DB_oe, DREQ
  );

endinterface

// File: rtl/dma_periph_fifo.sv
// dma_periph_fifo: show-ahead byte FIFO;
// push when full / pop when empty are dropped.
module dma_periph_fifo
  import dma_periph_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_q];
  assign count   = cnt_q;

  // Pointer/count update; pointers wrap mod DEPTH.
  always_comb begin
    wr_d  = wr_q + AW'(push_ok);
    rd_d  = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= din;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dma_peripheral_responder.sv
// dma_peripheral_responder: device-side DMA
// responder with TX/RX FIFOs and DREQ FSM.
module dma_peripheral_responder
  import dma_periph_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 single_mode,
  dma_peripheral_responder_if.slave bus,
  input  logic                 tx_push,
  input  logic [7:0]           tx_data,
  output logic                 tx_full,
  output logic [CNT_W-1:0]     tx_count,
  input  logic                 rx_pop,
  output logic [7:0]           rx_data,
  output logic                 rx_empty,
  output logic [CNT_W-1:0]     rx_count,
  output logic                 eop_flag,
  output logic [2:0]           err_flags,
  input  logic                 flag_clr
);

  localparam logic [CNT_W-1:0] FULL_CNT =
    CNT_W'(DEPTH);

  state_t     state_q, state_d;
  logic       dreq_q, dreq_d;
  logic       dir_q, dir_d;
  logic       strb_q, strb_d;
  logic [7:0] db_q, db_d;
  logic       eop_q, eop_d;
  logic [2:0] err_q, err_d;

  logic       tx_empty, rx_full;
  logic [7:0] tx_head;
  logic       proto, act_lo, strb_end;
  logic       eop_set, tx_pop_bus, rx_push_bus;
  logic       cond, cond_nx;
  logic [2:0] err_set;
  logic [CNT_W-1:0] tx_cnt_nx, rx_cnt_nx;

  dma_periph_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk(CLK), .rst_n(RESET_N),
    .push(tx_push), .din(tx_data),
    .pop(tx_pop_bus), .dout(tx_head),
    .full(tx_full), .empty(tx_empty),
    .count(tx_count)
  );

  dma_periph_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk(CLK), .rst_n(RESET_N),
    .push(rx_push_bus), .din(db_q),
    .pop(rx_pop), .dout(rx_data),
    .full(rx_full), .empty(rx_empty),
    .count(rx_count)
  );

  // A strobe ends on its rising edge under DACK;
  // the protocol-error cycle never counts as low.
  assign proto    = bus.DACK & ~bus.IOR_N
                  & ~bus.IOW_N;
  assign act_lo   = (dir_q == DIR_FROM_MEM) ?
                    ~bus.IOW_N : ~bus.IOR_N;
  assign strb_end = bus.DACK & ~act_lo & strb_q;
  assign eop_set  = bus.DACK & ~bus.EOP_N;

  assign tx_pop_bus  = strb_end & ~tx_empty
                     & (dir_q == DIR_TO_MEM);
  assign rx_push_bus = strb_end & ~rx_full
                     & (dir_q == DIR_FROM_MEM);

  assign err_set[ERR_UNDERRUN] = strb_end & tx_empty
                               & (dir_q == DIR_TO_MEM);
  assign err_set[ERR_OVERFLOW] = strb_end & rx_full
                               & (dir_q == DIR_FROM_MEM);
  assign err_set[ERR_PROTO]    = proto;

  // Occupancy after this edge, local traffic included.
  assign tx_cnt_nx = tx_count
                   + CNT_W'(tx_push & ~tx_full)
                   - CNT_W'(tx_pop_bus);
  assign rx_cnt_nx = rx_count
                   + CNT_W'(rx_push_bus)
                   - CNT_W'(rx_pop & ~rx_empty);

  assign cond    = (dir_q == DIR_FROM_MEM) ?
                   ~rx_full : ~tx_empty;
  assign cond_nx = (dir_q == DIR_FROM_MEM) ?
                   (rx_cnt_nx != FULL_CNT) :
                   (tx_cnt_nx != '0);

  // Read data drive; reset forces the bus off.
  assign bus.DB_oe  = RESET_N & bus.DACK
                    & ~bus.IOR_N & bus.IOW_N
                    & (dir_q == DIR_TO_MEM);
  assign bus.DB_out = ~bus.DB_oe ? 8'h00 :
                      tx_empty ? 8'hFF : tx_head;
  assign bus.DREQ   = dreq_q;

  assign eop_flag  = eop_q;
  assign err_flags = err_q;

  // Next-state for datapath regs, flags and FSM.
  always_comb begin
    dir_d  = en ? dir_q : dir;
    strb_d = bus.DACK & act_lo & ~proto;
    db_d   = (bus.DACK & ~bus.IOW_N) ?
             bus.DB_in : db_q;
    eop_d  = (eop_q & ~flag_clr) | eop_set;
    err_d  = (err_q & {3{~flag_clr}}) | err_set;

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en & cond & ~eop_q) state_d = REQ;
      end
      REQ: begin
        if (~en | eop_set)
          state_d = IDLE;
        else if (bus.DACK & act_lo)
          state_d = XFER;
      end
      XFER: begin
        if (strb_end)
          state_d = (~single_mode & en & ~eop_d
                     & cond_nx) ? REQ : GAP;
      end
      GAP: state_d = IDLE;
    endcase

    dreq_d = (state_d == REQ) | (state_d == XFER);
  end

  // State, registered DREQ and captured bus data.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      dreq_q  <= 1'b0;
      dir_q   <= DIR_TO_MEM;
      strb_q  <= 1'b0;
      db_q    <= '0;
      eop_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      dreq_q  <= dreq_d;
      dir_q   <= dir_d;
      strb_q  <= strb_d;
      db_q    <= db_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dma_peripheral_responder.sv
// tb_dma_peripheral_responder: directed stimulus,
// queue-based model compared every cycle.
module tb_dma_peripheral_responder;

  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       single_mode = 1'b0;
  logic       tx_push = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_pop = 1'b0;
  logic       flag_clr = 1'b0;
  logic       tx_full, rx_empty, eop_flag;
  logic [3:0] tx_count, rx_count;
  logic [7:0] rx_data;
  logic [2:0] err_flags;

  int n_run = 0;
  int n_fail = 0;

  dma_peripheral_responder_if bus();

  dma_peripheral_responder #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .en(en), .dir(dir),
    .single_mode(single_mode),
    .bus(bus),
    .tx_push(tx_push), .tx_data(tx_data),
    .tx_full(tx_full), .tx_count(tx_count),
    .rx_pop(rx_pop), .rx_data(rx_data),
    .rx_empty(rx_empty), .rx_count(rx_count),
    .eop_flag(eop_flag), .err_flags(err_flags),
    .flag_clr(flag_clr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Model: FIFOs as queues, flags as bits.
  logic [7:0] tq[$];
  logic [7:0] rq[$];
  logic       m_dir = 1'b0;
  logic       m_prev = 1'b0;
  logic       m_eop = 1'b0;
  logic [2:0] m_err = 3'b000;
  logic [7:0] m_db = 8'h00;
  logic       m_lo, m_se, m_pr;
  int         txn, rxn;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tq.delete();
      rq.delete();
      m_dir = 1'b0;
      m_prev = 1'b0;
      m_eop = 1'b0;
      m_err = 3'b000;
      m_db = 8'h00;
    end else begin
      m_pr = bus.DACK && !bus.IOR_N && !bus.IOW_N;
      m_lo = m_dir ? !bus.IOW_N : !bus.IOR_N;
      m_se = bus.DACK && !m_lo && m_prev;
      m_prev = bus.DACK && m_lo && !m_pr;
      txn = tq.size();
      rxn = rq.size();
      if (flag_clr) begin
        m_eop = 1'b0;
        m_err = 3'b000;
      end
      if (bus.DACK && !bus.EOP_N) m_eop = 1'b1;
      if (m_pr) m_err[2] = 1'b1;
      if (m_se && !m_dir && txn == 0)
        m_err[0] = 1'b1;
      if (m_se && m_dir && rxn == DEPTH)
        m_err[1] = 1'b1;
      if (m_se && !m_dir && txn > 0)
        void'(tq.pop_front());
      if (tx_push && txn < DEPTH)
        tq.push_back(tx_data);
      if (rx_pop && rxn > 0)
        void'(rq.pop_front());
      if (m_se && m_dir && rxn < DEPTH)
        rq.push_back(m_db);
      if (bus.DACK && !bus.IOW_N) m_db = bus.DB_in;
      if (!en) m_dir = dir;
    end
  end

  logic       e_oe;
  logic [7:0] e_out;

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    e_oe = RESET_N && !m_dir && bus.DACK
        && !bus.IOR_N && bus.IOW_N;
    e_out = !e_oe ? 8'h00 :
            (tq.size() == 0) ? 8'hFF : tq[0];
    chk("tx_count", tx_count, tq.size());
    chk("rx_count", rx_count, rq.size());
    chk("tx_full", tx_full, tq.size() == DEPTH);
    chk("rx_empty", rx_empty, rq.size() == 0);
    if (rq.size() > 0)
      chk("rx_data", rx_data, rq[0]);
    chk("eop_flag", eop_flag, m_eop);
    chk("err_flags", err_flags, m_err);
    chk("DB_oe", bus.DB_oe, e_oe);
    chk("DB_out", bus.DB_out, e_out);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_push = 1'b1;
    tx_data = d;
    step();
    tx_push = 1'b0;
  endtask

  task automatic pop_rx();
    rx_pop = 1'b1;
    step();
    rx_pop = 1'b0;
  endtask

  task automatic rd_pulse(output logic [7:0] seen,
                          output logic dq);
    bus.DACK = 1'b1;
    bus.IOR_N = 1'b0;
    step();
    seen = bus.DB_out;
    bus.IOR_N = 1'b1;
    step();
    dq = bus.DREQ;
    bus.DACK = 1'b0;
  endtask

  task automatic wr_pulse(input logic [7:0] d,
                          output logic dq);
    bus.DACK = 1'b1;
    bus.IOW_N = 1'b0;
    bus.DB_in = d;
    step();
    bus.IOW_N = 1'b1;
    step();
    dq = bus.DREQ;
    bus.DACK = 1'b0;
  endtask

  logic [7:0] sv;
  logic       dq;

  initial begin
    bus.DACK = 1'b0;
    bus.IOR_N = 1'b1;
    bus.IOW_N = 1'b1;
    bus.EOP_N = 1'b1;
    bus.DB_in = 8'h00;
    #1;
    chk("rst DREQ", bus.DREQ, 0);
    chk("rst DB_oe", bus.DB_oe, 0);
    chk("rst DB_out", bus.DB_out, 0);
    chk("rst tx_full", tx_full, 0);
    chk("rst rx_empty", rx_empty, 1);
    chk("rst counts", {tx_count, rx_count}, 0);
    chk("rst flags", {eop_flag, err_flags}, 0);
    step();
    RESET_N = 1'b1;
    step();

    // Demand read, burst mode.
    push_tx(8'hA1);
    push_tx(8'hB2);
    push_tx(8'hC3);
    en = 1'b1;
    step();
    chk("rd DREQ rise", bus.DREQ, 1);
    rd_pulse(sv, dq);
    chk("rd data0", sv, 8'hA1);
    chk("rd DREQ0", dq, 1);
    rd_pulse(sv, dq);
    chk("rd data1", sv, 8'hB2);
    chk("rd DREQ1", dq, 1);
    rd_pulse(sv, dq);
    chk("rd data2", sv, 8'hC3);
    chk("rd DREQ2", dq, 0);
    step();
    chk("rd DREQ idle", bus.DREQ, 0);
    chk("rd tx_count", tx_count, 0);

    // Single-mode write.
    en = 1'b0;
    dir = 1'b1;
    single_mode = 1'b1;
    step();
    en = 1'b1;
    step();
    chk("sw DREQ rise", bus.DREQ, 1);
    wr_pulse(8'h5A, dq);
    chk("sw DREQ gap", dq, 0);
    step();
    chk("sw DREQ idle", bus.DREQ, 0);
    step();
    chk("sw DREQ again", bus.DREQ, 1);
    wr_pulse(8'h3C, dq);
    chk("sw DREQ gap2", dq, 0);
    chk("sw rx_data", rx_data, 8'h5A);
    chk("sw rx_count", rx_count, 2);
    en = 1'b0;
    single_mode = 1'b0;
    pop_rx();
    chk("sw rx_data2", rx_data, 8'h3C);
    pop_rx();

    // RX overflow.
    en = 1'b1;
    step();
    chk("ov DREQ rise", bus.DREQ, 1);
    for (int k = 1; k <= 8; k++) begin
      wr_pulse(8'h0F + 8'(k), dq);
      chk("ov DREQ", dq, k < 8);
    end
    wr_pulse(8'hEE, dq);
    chk("ov DREQ9", dq, 0);
    chk("ov err", err_flags, 3'b010);
    chk("ov rx_count", rx_count, 8);
    chk("ov rx_full head", rx_data, 8'h10);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("ov clr", err_flags, 0);
    en = 1'b0;
    for (int k = 0; k < 8; k++) pop_rx();

    // EOP during the second of four reads.
    dir = 1'b0;
    step();
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    push_tx(8'h44);
    en = 1'b1;
    step();
    chk("eop DREQ rise", bus.DREQ, 1);
    rd_pulse(sv, dq);
    chk("eop data0", sv, 8'h11);
    bus.DACK = 1'b1;
    bus.IOR_N = 1'b0;
    step();
    chk("eop data1", bus.DB_out, 8'h22);
    bus.EOP_N = 1'b0;
    step();
    bus.EOP_N = 1'b1;
    bus.IOR_N = 1'b1;
    step();
    bus.DACK = 1'b0;
    chk("eop DREQ low", bus.DREQ, 0);
    chk("eop flag", eop_flag, 1);
    chk("eop tx_count", tx_count, 2);
    repeat (3) step();
    chk("eop DREQ held", bus.DREQ, 0);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("eop clr", eop_flag, 0);
    chk("eop DREQ clr", bus.DREQ, 0);
    step();
    chk("eop DREQ resume", bus.DREQ, 1);
    en = 1'b0;
    step();
    rd_pulse(sv, dq);
    chk("eop data2", sv, 8'h33);
    rd_pulse(sv, dq);
    chk("eop data3", sv, 8'h44);

    // Protocol error, then underrun.
    push_tx(8'h77);
    bus.DACK = 1'b1;
    bus.IOR_N = 1'b0;
    bus.IOW_N = 1'b0;
    step();
    chk("pr err", err_flags, 3'b100);
    chk("pr DB_oe", bus.DB_oe, 0);
    bus.IOR_N = 1'b1;
    bus.IOW_N = 1'b1;
    step();
    bus.DACK = 1'b0;
    chk("pr tx_count", tx_count, 1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("pr clr", err_flags, 0);
    rd_pulse(sv, dq);
    chk("ur data", sv, 8'h77);
    rd_pulse(sv, dq);
    chk("ur empty bus", sv, 8'hFF);
    chk("ur err", err_flags, 3'b001);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;

    // Reset while a transfer is in flight.
    push_tx(8'h01);
    push_tx(8'h02);
    push_tx(8'h03);
    en = 1'b1;
    step();
    bus.DACK = 1'b1;
    bus.IOR_N = 1'b0;
    step();
    chk("mr DREQ", bus.DREQ, 1);
    chk("mr tx_count", tx_count, 3);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mr DREQ rst", bus.DREQ, 0);
    chk("mr DB_oe rst", bus.DB_oe, 0);
    chk("mr tx_count rst", tx_count, 0);
    bus.DACK = 1'b0;
    bus.IOR_N = 1'b1;
    en = 1'b0;
    step();
    RESET_N = 1'b1;
    step();
    step();
    chk("mr DREQ idle", bus.DREQ, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
